chan_select_rr: RTL

Registered N-channel data selector with valid/ready handshaking on every input channel and on the output. It succeeds the combinational 8-channel chip-select mux: it adds a parametrised channel count and width, back-pressure, and a round-robin arbitration mode alongside fixed `sel` steering. It sits between multiple producer streams and a single consumer in the datapath.

---
 rtl/chsel_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/chan_select_rr.sv | 95 +++++++++
 3 files changed

// File: rtl/chsel_pkg.sv
// Shared constants and helpers for the chan_select_rr channel selector.
package chsel_pkg;

  localparam logic CHSEL_MODE_FIXED = 1'b0;
  localparam logic CHSEL_MODE_RR    = 1'b1;

  // Converts a one-hot grant (up to 16 channels) to a channel index; zero in gives 0.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo CH.
module rr_arbiter #(
  parameter int CH = 8,
  parameter int SW = 3
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic [CH-1:0] gnt
);

  logic found;

  // k is the distance from ptr; the nearest requester wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= CH; k++) begin
      for (int i = 0; i < CH; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % CH)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/chan_select_rr.sv
// Registered CH-channel selector with fixed or round-robin steering.
// Round-robin is built only when the CHSEL_RR_EN macro is defined.
module chan_select_rr
  import chsel_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int CH = 8,
  localparam int SW = $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_n,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0] in_valid,
  output logic [CH-1:0] in_ready,
  output logic [N-1:0]  out_data,
  output logic [SW-1:0] out_ch,
  output logic          out_valid,
  input  logic          out_ready
);

  // Handshake: a word moves on channel i at a rising edge when in_valid[i] and
  // in_ready[i] are both high; the output word moves when out_valid and out_ready are.
  logic          load;
  logic          accept_en;
  logic          xfer;
  logic [CH-1:0] gnt;
  logic [CH-1:0] gnt_fix;
  logic [SW-1:0] gnt_idx;
  logic [N-1:0]  gnt_data;

  assign load      = !out_valid || out_ready;
  assign accept_en = load && !cs_n;
  assign in_ready  = gnt & {CH{accept_en}};
  assign xfer      = |(in_valid & in_ready);
  assign gnt_idx   = SW'(onehot_to_idx(16'(gnt)));

  // An out-of-range sel matches no channel and therefore grants nothing.
  always_comb begin
    gnt_fix = '0;
    for (int i = 0; i < CH; i++) begin
      if (int'(sel) == i) gnt_fix[i] = in_valid[i];
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CH; i++) begin
      gnt_data = gnt_data | (in_data[i*N +: N] & {N{gnt[i]}});
    end
  end

`ifdef CHSEL_RR_EN
  logic [SW-1:0] ptr;
  logic [CH-1:0] gnt_rr;

  rr_arbiter #(.CH(CH), .SW(SW)) u_rr_arbiter (
    .req (in_valid),
    .ptr (ptr),
    .gnt (gnt_rr)
  );

  assign gnt = (mode == CHSEL_MODE_RR) ? gnt_rr : gnt_fix;

  // ptr only advances on round-robin transfers so fixed-mode traffic keeps its place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SW'(CH - 1);
    end else if (xfer && (mode == CHSEL_MODE_RR)) begin
      ptr <= gnt_idx;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign gnt         = gnt_fix;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= gnt_data;
        out_ch   <= gnt_idx;
      end
    end
  end

endmodule
